// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// AluExecStage (module alu_exec_stage)
//
// Registered ALU execution stage. It takes a 3-bit ALU control code and two
// operands, computes the result combinationally, and captures it into a
// 2-entry output FIFO. Valid/ready handshakes on both sides let the decode
// side and the writeback side stall independently of each other.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-low reset
//   in_valid     request valid
//   in_ready     stage can accept a request (depends on registered state only)
//   alu_control  operation code from the ALU decoder
//   src_a/src_b  operands
//   out_valid    head buffer entry valid
//   out_ready    consumer accepts the head entry this cycle
//   out_result   head entry result
//   out_zero     head entry result is zero
//   out_illegal  head entry was produced from an unsupported code
// ---------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal
);

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpSlt = 3'b101
    } aluOpT;

    logic [WIDTH-1:0] resultMem_q [2];
    logic [1:0]       zeroMem_q;
    logic [1:0]       illegalMem_q;
    logic             headPtr_q;
    logic             headPtr_d;
    logic             tailPtr_q;
    logic             tailPtr_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    logic [WIDTH-1:0] aluResult;
    logic             aluIllegal;
    logic             aluZero;
    logic             signedLess;
    logic             push;
    logic             pop;

    // Operation select. SLT compares as two's complement and zero-extends the
    // single-bit outcome. Unsupported codes yield 0 and flag the entry; the
    // entry still flows through the buffer like any other.
    always_comb begin
        aluResult  = '0;
        aluIllegal = 1'b0;
        signedLess = ($signed(src_a) < $signed(src_b));
        case (alu_control)
            OpAdd:   aluResult = src_a + src_b;
            OpSub:   aluResult = src_a - src_b;
            OpAnd:   aluResult = src_a & src_b;
            OpOr:    aluResult = src_a | src_b;
            OpSlt:   aluResult = {{(WIDTH-1){1'b0}}, signedLess};
            default: aluIllegal = 1'b1;
        endcase
        aluZero = (aluResult == '0);
    end

    // Handshakes are derived from the registered occupancy only, so in_ready
    // never combinationally depends on out_ready and nothing is bypassed.
    assign in_ready    = (count_q != 2'd2);
    assign out_valid   = (count_q != 2'd0);
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;

    assign out_result  = resultMem_q[headPtr_q];
    assign out_zero    = zeroMem_q[headPtr_q];
    assign out_illegal = illegalMem_q[headPtr_q];

    // Pointer and occupancy next state. With a 2-entry buffer the 1-bit
    // pointers wrap 1 -> 0 naturally; a simultaneous push and pop moves both
    // pointers and leaves the count alone.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (push) begin
            tailPtr_d = ~tailPtr_q;
        end
        if (pop) begin
            headPtr_d = ~headPtr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Reset discards every buffered entry and clears storage, so the head
    // fields read as zero right after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                resultMem_q[i] <= '0;
            end
            zeroMem_q    <= '0;
            illegalMem_q <= '0;
            headPtr_q    <= 1'b0;
            tailPtr_q    <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            if (push) begin
                resultMem_q[tailPtr_q]  <= aluResult;
                zeroMem_q[tailPtr_q]    <= aluZero;
                illegalMem_q[tailPtr_q] <= aluIllegal;
            end
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// TbAluExecStage (module tb_alu_exec_stage)
//
// Directed testbench for alu_exec_stage. Inputs change on the falling edge,
// the DUT samples on the rising edge, and outputs are observed on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_illegal;

    int total;
    int bad;

    alu_exec_stage #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset for two edges, then idle with nothing pushed.
    task automatic test_reset();
        rst         = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = 3'b000;
        src_a       = '0;
        src_b       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_result got=%h want=0", out_result); end
        total++; if (out_zero !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_zero got=%b want=0", out_zero); end
        total++; if (out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_illegal got=%b want=0", out_illegal); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_out_valid got=%b want=0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("[TB] FAIL idle_out_result got=%h want=0", out_result); end
    endtask

    // One request with out_ready high: result visible the cycle after
    // accept, then popped so the buffer is empty again.
    task automatic applyStimulus(input string name, input logic [2:0] ctrl,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] expRes, input logic expZero,
                                 input logic expIll);
        @(negedge clk);
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        alu_control = ctrl;
        src_a       = a;
        src_b       = b;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL %s_in_ready got=%b want=1", name, in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL %s_valid got=%b want=1", name, out_valid); end
        total++; if (out_result !== expRes) begin bad++; $display("[TB] FAIL %s_result got=%h want=%h", name, out_result, expRes); end
        total++; if (out_zero !== expZero) begin bad++; $display("[TB] FAIL %s_zero got=%b want=%b", name, out_zero, expZero); end
        total++; if (out_illegal !== expIll) begin bad++; $display("[TB] FAIL %s_illegal got=%b want=%b", name, out_illegal, expIll); end
        @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s_drained got=%b want=0", name, out_valid); end
    endtask

    task automatic test_ops();
        applyStimulus("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0);
        applyStimulus("sub",      3'b001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        applyStimulus("and",      3'b010, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0);
        applyStimulus("or",       3'b011, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0);
        applyStimulus("slt_true", 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0);
        applyStimulus("slt_false",3'b101, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        applyStimulus("ill_100", 3'b100, 32'd3, 32'd4, 32'h0, 1'b1, 1'b1);
        applyStimulus("add_mid", 3'b000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        applyStimulus("ill_110", 3'b110, 32'd3, 32'd4, 32'h0, 1'b1, 1'b1);
        applyStimulus("ill_111", 3'b111, 32'd3, 32'd4, 32'h0, 1'b1, 1'b1);
    endtask

    // Fill with out_ready low, check a third push is held off, then drain.
    task automatic test_backpressure();
        @(negedge clk);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        alu_control = 3'b000;
        src_a = 32'd1; src_b = 32'd1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_after1 got=%b want=1", in_ready); end
        total++; if (out_result !== 32'd2) begin bad++; $display("[TB] FAIL bp_head1 got=%h want=2", out_result); end
        src_a = 32'd2; src_b = 32'd2;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full got=%b want=0", in_ready); end
        src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_held got=%b want=0", in_ready); end
        total++; if (out_result !== 32'd2) begin bad++; $display("[TB] FAIL bp_stable got=%h want=2", out_result); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_after_pop got=%b want=1", in_ready); end
        total++; if (out_result !== 32'd4) begin bad++; $display("[TB] FAIL bp_second got=%h want=4", out_result); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_second_valid got=%b want=1", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_third got=%b want=0", out_valid); end
        out_ready = 1'b0;
    endtask

    // Ten back-to-back adds with out_ready toggling; a queue model predicts
    // occupancy and the order of results.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] expQ[$];
        int modelCount = 0;
        int sent = 0;
        int received = 0;
        int cyc = 0;
        bit doPush;
        bit doPop;
        while (received < 10 && cyc < 80) begin
            @(negedge clk);
            total++; if (in_ready !== (modelCount != 2)) begin bad++; $display("[TB] FAIL b2b_in_ready cyc=%0d got=%b count=%0d", cyc, in_ready, modelCount); end
            total++; if (out_valid !== (modelCount != 0)) begin bad++; $display("[TB] FAIL b2b_out_valid cyc=%0d got=%b count=%0d", cyc, out_valid, modelCount); end
            out_ready   = (cyc % 2 == 0);
            in_valid    = (sent < 10);
            alu_control = 3'b000;
            src_a       = sent * 3;
            src_b       = 32'd100;
            doPop  = (modelCount != 0) && out_ready;
            doPush = in_valid && (modelCount != 2);
            if (doPop) begin
                total++; if (out_result !== expQ[0]) begin bad++; $display("[TB] FAIL b2b_order idx=%0d got=%h want=%h", received, out_result, expQ[0]); end
                void'(expQ.pop_front());
                received++;
                modelCount--;
            end
            if (doPush) begin
                expQ.push_back(sent * 3 + 100);
                sent++;
                modelCount++;
            end
            cyc++;
        end
        total++; if (received != 10) begin bad++; $display("[TB] FAIL b2b_timeout got=%0d want=10", received); end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_empty_end got=%b want=0", out_valid); end
    endtask

    // Reset with a full buffer, then confirm no stale entry comes out.
    task automatic test_reset_mid();
        @(negedge clk);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        alu_control = 3'b000;
        src_a = 32'd5; src_b = 32'd5;
        @(negedge clk);
        src_a = 32'd6; src_b = 32'd6;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rm_full got=%b want=0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rm_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rm_in_ready got=%b want=1", in_ready); end
        total++; if (out_result !== 32'h0) begin bad++; $display("[TB] FAIL rm_cleared got=%h want=0", out_result); end
        in_valid = 1'b1;
        out_ready = 1'b1;
        src_a = 32'd7; src_b = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_result !== 32'd8) begin bad++; $display("[TB] FAIL rm_new got=%h want=8", out_result); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rm_new_valid got=%b want=1", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rm_no_stale got=%b want=0", out_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ops();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
